riscv_fetch_queue: RTL and testbench

- Instruction fetch front-end that sits directly upstream of the IF/ID pipeline register bank.
- Issues in-order word requests to instruction memory and buffers the returned {pc, inst} pairs in a small FIFO.
- Presents buffered entries to decode with a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue and discarding responses still in flight.

---
 rtl/riscv_fetch_queue_pkg.sv | 20 ++
 rtl/riscv_fetch_fifo.sv | 47 ++++
 rtl/riscv_fetch_queue.sv | 111 +++++++++++
 tb/tb_riscv_fetch_queue.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_queue_pkg.sv
// Shared fetch-path definitions: XLEN, NOP filler and PC step, plus the queued entry type.
// Build option RISCV_FETCH_BYPASS_EN is consumed by riscv_fetch_queue.
`ifndef RISCV_CONFIGS_DEFINED
`define RISCV_CONFIGS_DEFINED
`define XLEN 32
`define NOP_INST 32'h0000_0013
`define PC_STEP 4
`endif

package riscv_fetch_queue_pkg;
    localparam int XLEN = `XLEN;
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(`PC_STEP);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [31:0]     NOP_INST   = `NOP_INST;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } fetch_entry_t;
endpackage

// File: rtl/riscv_fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of {pc, inst} pairs with flush; pointers carry an extra wrap bit.
// Latency: write visible at head the cycle after push.
// Backpressure: push while full and pop while empty are ignored; flush wins over both.
module riscv_fetch_fifo
    import riscv_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       push,
    input  fetch_entry_t               push_dat,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     occupancy,
    output fetch_entry_t               head_dat
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;

    assign occupancy = wr_ptr - rd_ptr;
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_dat  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push && !full && !flush && !i_rst)
            mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

// File: rtl/riscv_fetch_queue.sv
// In-order instruction fetch front-end: credit-limited imem requests, {pc, inst} FIFO, redirect flush.
// Latency: rvalid to o_valid 1 cycle when empty (0 with RISCV_FETCH_BYPASS_EN defined).
// Backpressure: queued + live in-flight requests capped at DEPTH; decode stalls via i_ready.
module riscv_fetch_queue
    import riscv_fetch_queue_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [31:0]     i_imem_rdata,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [31:0]     o_inst,
    input  logic            i_ready
);
    localparam int              CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]     CAP     = (CW+1)'(DEPTH);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   occupancy;
    logic [CW:0]     live;
    logic            req_fire;
    logic            rsp_live;
    logic            rsp_keep;
    logic            bypass;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    fetch_entry_t    head;
    fetch_entry_t    push_dat;

    // Responses already marked for discard no longer hold a FIFO slot in reserve.
    assign live        = {1'b0, occupancy} + {1'b0, outstanding} - {1'b0, discard};
    assign o_imem_req  = !i_rst && !i_redirect && (live < CAP);
    assign o_imem_addr = fetch_pc;
    assign req_fire    = o_imem_req && i_imem_gnt;
    assign rsp_live    = i_imem_rvalid && (outstanding != '0);
    assign rsp_keep    = rsp_live && (discard == '0) && !i_redirect;

`ifdef RISCV_FETCH_BYPASS_EN
    assign bypass = empty && rsp_keep;
`else
    assign bypass = 1'b0;
`endif

    assign o_valid  = !i_rst && !i_redirect && (!empty || bypass);
    assign o_pc     = bypass ? resp_pc : head.pc;
    assign o_inst   = !o_valid ? NOP_INST : (bypass ? i_imem_rdata : head.inst);
    assign pop      = o_valid && i_ready && !empty;
    assign push     = rsp_keep && !(bypass && i_ready);
    assign push_dat = '{pc: resp_pc, inst: i_imem_rdata};

    riscv_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .push      (push),
        .push_dat  (push_dat),
        .pop       (pop),
        .flush     (i_redirect),
        .full      (full),
        .empty     (empty),
        .occupancy (occupancy),
        .head_dat  (head)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc    <= RESET_PC & ALIGN_MASK;
            resp_pc     <= RESET_PC & ALIGN_MASK;
            outstanding <= '0;
            discard     <= '0;
        end else if (i_redirect) begin
            // Every response still owed after this cycle is stale.
            fetch_pc    <= i_redirect_pc & ALIGN_MASK;
            resp_pc     <= i_redirect_pc & ALIGN_MASK;
            outstanding <= outstanding - (rsp_live ? CNT_ONE : '0);
            discard     <= outstanding - (rsp_live ? CNT_ONE : '0);
        end else begin
            if (req_fire)
                fetch_pc <= fetch_pc + PC_STEP;
            if (rsp_keep)
                resp_pc <= resp_pc + PC_STEP;
            if (req_fire && !rsp_live)
                outstanding <= outstanding + CNT_ONE;
            else if (!req_fire && rsp_live)
                outstanding <= outstanding - CNT_ONE;
            if (rsp_live && (discard != '0))
                discard <= discard - CNT_ONE;
        end
    end

    a_no_orphan_rvalid: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_imem_rvalid && (outstanding == '0)));
    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(push && full && !i_redirect));
endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Directed bench for riscv_fetch_queue: imem responder returns data one cycle after grant.
module tb_riscv_fetch_queue;
    import riscv_fetch_queue_pkg::*;

    localparam logic [XLEN-1:0] RST_PC = 32'h0000_0100;
    localparam int              DEPTH  = 4;
`ifdef RISCV_FETCH_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic            o_imem_req;
    logic [XLEN-1:0] o_imem_addr;
    logic            i_imem_gnt = 1'b0;
    logic            i_imem_rvalid = 1'b0;
    logic [31:0]     i_imem_rdata = '0;
    logic            i_redirect = 1'b0;
    logic [XLEN-1:0] i_redirect_pc = '0;
    logic            o_valid;
    logic [XLEN-1:0] o_pc;
    logic [31:0]     o_inst;
    logic            i_ready = 1'b0;

    int              errors = 0;
    int              checks = 0;
    int              req_count = 0;
    bit              resp_en = 1'b0;
    logic [XLEN-1:0] pend_q [$];

    riscv_fetch_queue #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_valid       (o_valid),
        .o_pc          (o_pc),
        .o_inst        (o_inst),
        .i_ready       (i_ready)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] inst_of(input logic [XLEN-1:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Samples the grant just before the edge, then drives the next response at the negedge.
    task automatic tick();
        logic            fire;
        logic [XLEN-1:0] a;
        fire = o_imem_req && i_imem_gnt;
        a    = o_imem_addr;
        @(posedge i_clk);
        if (fire) begin
            pend_q.push_back(a);
            req_count++;
        end
        @(negedge i_clk);
        if (resp_en && pend_q.size() > 0) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = inst_of(pend_q.pop_front());
        end else begin
            i_imem_rvalid = 1'b0;
            i_imem_rdata  = '0;
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1; resp_en = 1'b0; i_imem_gnt = 1'b0;
        i_redirect = 1'b0; i_ready = 1'b0;
        tick();
        tick();
        pend_q.delete();
        i_rst = 1'b0; i_imem_rvalid = 1'b0; req_count = 0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick();
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", o_imem_req); end
        checks++; if (o_inst !== 32'h0000_0013) begin errors++; $display("FAIL reset_nop: got %h want 00000013", o_inst); end
        i_rst = 1'b0;
        #1;
        checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0000_0100) begin
            errors++; $display("FAIL reset_first_req: got req=%b addr=%h want req=1 addr=00000100", o_imem_req, o_imem_addr); end
    endtask

    task automatic test_stream();
        logic [XLEN-1:0] exp_pc;
        do_reset();
        i_imem_gnt = 1'b1; resp_en = 1'b1; i_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++; if (o_imem_addr !== 32'h0000_0100 + 32'(4*k)) begin
                errors++; $display("FAIL stream_addr[%0d]: got %h want %h", k, o_imem_addr, 32'h0000_0100 + 32'(4*k)); end
            if (k >= LAT + 1) begin
                exp_pc = 32'h0000_0100 + 32'(4*(k-1-LAT));
                checks++; if (o_valid !== 1'b1 || o_pc !== exp_pc || o_inst !== inst_of(exp_pc)) begin
                    errors++; $display("FAIL stream_out[%0d]: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                                       k, o_valid, o_pc, o_inst, exp_pc, inst_of(exp_pc)); end
            end else begin
                checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stream_idle[%0d]: got %b want 0", k, o_valid); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        i_imem_gnt = 1'b1; resp_en = 1'b1; i_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            tick();
        end
        #1;
        checks++; if (req_count !== 4) begin errors++; $display("FAIL bp_req_count: got %0d want 4", req_count); end
        checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_stall: got %b want 0", o_imem_req); end
        checks++; if (dut.occupancy !== 3'd4) begin errors++; $display("FAIL bp_occupancy: got %0d want 4", dut.occupancy); end
        i_ready = 1'b1;
        #1;
        checks++; if (o_valid !== 1'b1 || o_pc !== 32'h0000_0100 || o_inst !== inst_of(32'h0000_0100)) begin
            errors++; $display("FAIL bp_head: got v=%b pc=%h inst=%h want v=1 pc=00000100", o_valid, o_pc, o_inst); end
        tick();
        i_ready = 1'b0;
        #1;
        checks++; if (o_pc !== 32'h0000_0104) begin errors++; $display("FAIL bp_next_head: got %h want 00000104", o_pc); end
        checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0000_0110) begin
            errors++; $display("FAIL bp_refill_req: got req=%b addr=%h want req=1 addr=00000110", o_imem_req, o_imem_addr); end
        tick();
        tick();
        tick();
        #1;
        checks++; if (req_count !== 5 || o_imem_req !== 1'b0) begin
            errors++; $display("FAIL bp_single_refill: got count=%0d req=%b want count=5 req=0", req_count, o_imem_req); end
    endtask

    task automatic test_redirect();
        bit              found;
        int              idx;
        logic [XLEN-1:0] first_pc;
        logic [31:0]     first_inst;
        do_reset();
        i_imem_gnt = 1'b1; resp_en = 1'b0; i_ready = 1'b1;
        #1; tick();
        #1; tick();
        i_imem_gnt = 1'b0; i_redirect = 1'b1; i_redirect_pc = 32'h0000_0203;
        #1;
        checks++; if (o_imem_req !== 1'b0 || o_valid !== 1'b0) begin
            errors++; $display("FAIL redir_block: got req=%b v=%b want 0 0", o_imem_req, o_valid); end
        checks++; if (dut.outstanding !== 3'd2) begin errors++; $display("FAIL redir_inflight: got %0d want 2", dut.outstanding); end
        tick();
        i_redirect = 1'b0; i_imem_gnt = 1'b1; resp_en = 1'b1;
        #1;
        checks++; if (o_imem_addr !== 32'h0000_0200) begin errors++; $display("FAIL redir_addr: got %h want 00000200", o_imem_addr); end
        checks++; if (dut.discard !== 3'd2) begin errors++; $display("FAIL redir_discard: got %0d want 2", dut.discard); end
        found = 1'b0; idx = -1; first_pc = '0; first_inst = '0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (!found && o_valid) begin
                found = 1'b1; idx = i; first_pc = o_pc; first_inst = o_inst;
            end
            tick();
        end
        checks++; if (idx !== 3 + LAT) begin errors++; $display("FAIL redir_first_cycle: got %0d want %0d", idx, 3 + LAT); end
        checks++; if (first_pc !== 32'h0000_0200 || first_inst !== inst_of(32'h0000_0200)) begin
            errors++; $display("FAIL redir_first_entry: got pc=%h inst=%h want pc=00000200 inst=%h", first_pc, first_inst, inst_of(32'h0000_0200)); end
    endtask

    task automatic test_redirect_rvalid();
        bit              found;
        int              idx;
        logic [XLEN-1:0] first_pc;
        logic [31:0]     first_inst;
        do_reset();
        i_imem_gnt = 1'b1; resp_en = 1'b1; i_ready = 1'b1;
        #1; tick();
        i_imem_gnt = 1'b0; i_redirect = 1'b1; i_redirect_pc = 32'h0000_0300;
        #1;
        checks++; if (dut.outstanding !== 3'd1 || i_imem_rvalid !== 1'b1) begin
            errors++; $display("FAIL rr_setup: got out=%0d rvalid=%b want 1 1", dut.outstanding, i_imem_rvalid); end
        tick();
        i_redirect = 1'b0; i_imem_gnt = 1'b1;
        #1;
        checks++; if (dut.discard !== 3'd0 || dut.outstanding !== 3'd0) begin
            errors++; $display("FAIL rr_counters: got disc=%0d out=%0d want 0 0", dut.discard, dut.outstanding); end
        checks++; if (o_valid !== 1'b0 || o_imem_addr !== 32'h0000_0300) begin
            errors++; $display("FAIL rr_restart: got v=%b addr=%h want v=0 addr=00000300", o_valid, o_imem_addr); end
        found = 1'b0; idx = -1; first_pc = '0; first_inst = '0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (!found && o_valid) begin
                found = 1'b1; idx = i; first_pc = o_pc; first_inst = o_inst;
            end
            tick();
        end
        checks++; if (idx !== 1 + LAT || first_pc !== 32'h0000_0300 || first_inst !== inst_of(32'h0000_0300)) begin
            errors++; $display("FAIL rr_first_entry: got cyc=%0d pc=%h inst=%h want cyc=%0d pc=00000300 inst=%h",
                               idx, first_pc, first_inst, 1 + LAT, inst_of(32'h0000_0300)); end
    endtask

    task automatic test_wrap();
        do_reset();
        i_ready = 1'b1; resp_en = 1'b1; i_imem_gnt = 1'b0;
        i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFE;
        #1; tick();
        i_redirect = 1'b0; i_imem_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (i == 0) begin
                checks++; if (o_imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0: got %h want fffffffc", o_imem_addr); end
            end
            if (i == 1) begin
                checks++; if (o_imem_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr1: got %h want 00000000", o_imem_addr); end
            end
            if (i == 1 + LAT) begin
                checks++; if (o_valid !== 1'b1 || o_pc !== 32'hFFFF_FFFC) begin
                    errors++; $display("FAIL wrap_pc0: got v=%b pc=%h want v=1 pc=fffffffc", o_valid, o_pc); end
            end
            if (i == 2 + LAT) begin
                checks++; if (o_valid !== 1'b1 || o_pc !== 32'h0000_0000 || o_inst !== inst_of(32'h0000_0000)) begin
                    errors++; $display("FAIL wrap_pc1: got v=%b pc=%h inst=%h want v=1 pc=00000000", o_valid, o_pc, o_inst); end
            end
            tick();
        end
    endtask

    task automatic test_reset_midstream();
        bit              found;
        int              idx;
        logic [XLEN-1:0] first_pc;
        do_reset();
        i_imem_gnt = 1'b1; resp_en = 1'b1; i_ready = 1'b0;
        #1; tick();
        #1; tick();
        #1; tick();
        resp_en = 1'b0;
        #1; tick();
        #1;
        checks++; if (dut.occupancy !== 3'd3 || dut.outstanding !== 3'd1) begin
            errors++; $display("FAIL mid_setup: got occ=%0d out=%0d want 3 1", dut.occupancy, dut.outstanding); end
        i_rst = 1'b1; resp_en = 1'b1;
        #1; tick();
        #1;
        checks++; if (o_valid !== 1'b0 || o_imem_req !== 1'b0) begin
            errors++; $display("FAIL mid_reset_out: got v=%b req=%b want 0 0", o_valid, o_imem_req); end
        tick();
        i_rst = 1'b0; i_ready = 1'b1;
        #1;
        checks++; if (o_imem_addr !== 32'h0000_0100 || o_valid !== 1'b0) begin
            errors++; $display("FAIL mid_restart: got addr=%h v=%b want 00000100 0", o_imem_addr, o_valid); end
        checks++; if (dut.outstanding !== 3'd0 || dut.occupancy !== 3'd0) begin
            errors++; $display("FAIL mid_cleared: got out=%0d occ=%0d want 0 0", dut.outstanding, dut.occupancy); end
        found = 1'b0; idx = -1; first_pc = '0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (!found && o_valid) begin
                found = 1'b1; idx = i; first_pc = o_pc;
            end
            tick();
        end
        checks++; if (idx !== 1 + LAT || first_pc !== 32'h0000_0100) begin
            errors++; $display("FAIL mid_first_entry: got cyc=%0d pc=%h want cyc=%0d pc=00000100", idx, first_pc, 1 + LAT); end
    endtask

    task automatic test_bypass();
        logic        exp_fwd;
        logic [31:0] exp_inst_a;
        logic [31:0] exp_inst_b;
        exp_fwd    = (LAT == 0);
        exp_inst_a = exp_fwd ? inst_of(32'h0000_0100) : 32'h0000_0013;
        exp_inst_b = exp_fwd ? 32'h0000_0013 : inst_of(32'h0000_0100);
        do_reset();
        i_imem_gnt = 1'b1; resp_en = 1'b1; i_ready = 1'b1;
        #1; tick();
        i_imem_gnt = 1'b0;
        #1;
        checks++; if (o_valid !== exp_fwd || o_inst !== exp_inst_a) begin
            errors++; $display("FAIL byp_same_cycle: got v=%b inst=%h want v=%b inst=%h", o_valid, o_inst, exp_fwd, exp_inst_a); end
        tick();
        #1;
        checks++; if (dut.occupancy !== 3'(LAT)) begin errors++; $display("FAIL byp_occupancy: got %0d want %0d", dut.occupancy, LAT); end
        checks++; if (o_valid !== !exp_fwd || o_inst !== exp_inst_b) begin
            errors++; $display("FAIL byp_next_cycle: got v=%b inst=%h want v=%b inst=%h", o_valid, o_inst, !exp_fwd, exp_inst_b); end
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_rvalid();
        test_wrap();
        test_reset_midstream();
        test_bypass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end
endmodule
